cpu_core: RTL and testbench
===========================

Name: cpu_core

Overview:
Second-generation 6502-style CPU core for the console: parametrised clock divider and reset vector, an expanded instruction subset (loads, transfers, inc/dec, JMP abs, STA abs), N/Z flag maintenance, a bus write path and a halt-on-illegal-opcode state. Sits between the system clock and the memory/bus fabric. Issues read/write requests on a single 16-bit address bus, one request per CPU tick.

Parameters:
CLOCK_DIVIDER, 12, system clocks per CPU tick (>=1; 1 = tick every clock)
RESET_VECTOR, 16'hFFFC, address of reset vector low byte (high byte at RESET_VECTOR+1, 16-bit wrap)
STACK_RESET, 8'hFD, stack pointer value after reset

Ports:
clock_i  in  1  system clock
reset_i  in  1  asynchronous, active-high reset
data_i  in  8  read data from bus
data_valid_i  in  1  data_i valid for the current read request
data_o  out  8  write data
data_valid_o  out  1  1 = current request is a write of data_o
address_o  out  16  request address
address_valid_o  out  1  request active (read when data_valid_o=0, write when 1)
halted_o  out  1  core stopped on illegal opcode

Behaviour:
- Interface: one clock (clock_i); reset_i asynchronous, active-high; all state returns to reset values immediately on assertion.
- Tick: divider counts 0..CLOCK_DIVIDER-1; tick pulses for one clock when count = CLOCK_DIVIDER-1. First tick occurs CLOCK_DIVIDER clocks after reset release. All state below advances only on a tick.
- Reset values: address_o=RESET_VECTOR, address_valid_o=1, data_o=0, data_valid_o=0, halted_o=0, A=X=Y=0, SP=STACK_RESET, P=8'h34, PC=0, state=RESET_LO.
- Read completion: a read completes on a tick with data_valid_i=1; otherwise state holds and the request stays asserted, unchanged.
- RESET_LO, on read complete: PC[7:0]<=data; address_o<=RESET_VECTOR+1; goto RESET_HI.
- RESET_HI, on read complete: PC[15:8]<=data; address_o<={data,PC[7:0]}; goto FETCH.
- FETCH, on read complete: latch opcode; PC<=PC+1.
  - Immediate/absolute opcode: address_o<=PC+1; goto OPERAND_LO.
  - Implied opcode: address_valid_o<=0; goto EXEC.
  - Undefined opcode: address_valid_o<=0; halted_o<=1; goto HALT.
- Opcodes:
  - Immediate: LDA A9, LDX A2, LDY A0.
  - Implied: NOP EA, TAX AA, TAY A8, TXA 8A, TYA 98, INX E8, INY C8, DEX CA, DEY 88.
  - Absolute: JMP 4C, STA 8D.
- EXEC (next tick, no bus access): perform implied op; address_o<=PC; address_valid_o<=1; goto FETCH. Every implied op takes 2 ticks.
- OPERAND_LO, on read complete:
  - Immediate: load destination register; PC<=PC+1; address_o<=PC+1; goto FETCH.
  - Absolute: latch operand low byte; PC<=PC+1; address_o<=PC+1; goto OPERAND_HI.
- OPERAND_HI, on read complete:
  - JMP: PC<={data,lo}; address_o<={data,lo}; goto FETCH.
  - STA: PC<=PC+1; address_o<={data,lo}; data_o<=A; data_valid_o<=1; goto WRITE.
- WRITE: write is presented for exactly one tick and needs no acknowledge. On the next tick: data_valid_o<=0; address_o<=PC; goto FETCH.
- Flags: loads, transfers and inc/dec set N=result[7] and Z=(result==0); NOP/JMP/STA leave P unchanged; other P bits never change.
- Arithmetic: 8-bit registers wrap (FF+1=00 with Z=1, N=0; 00-1=FF with N=1, Z=0). PC wraps FFFF->0000.
- HALT: address_valid_o=0, data_valid_o=0, halted_o=1, registers frozen; the only exit is reset.
- data_valid_i is ignored outside read states and outside ticks.

Optional Feature:
Macro CPU_CORE_DEBUG_PORTS_EN.
- Defined: adds outputs clock_ready_o(1), program_counter_o(16), accumulator_o(8), index_x_o(8), index_y_o(8), status_o(8), stack_pointer_o(8), opcode_o(8), continuously driven from internal registers.
- Undefined: ports absent; core behaviour identical.

Test Plan:
- Reset release, CLOCK_DIVIDER=4, memory FFFC=00, FFFD=80 -> reads issued at FFFC then FFFD; first FETCH address 8000; PC=8000.
- Program A9 80, AA, E8 -> A=80 (N=1, Z=0); X=80; X=81, N=1; fetch address sequence 8000, 8001, 8002, 8003, 8004.
- Program A2 FF, E8, 88 -> X=00 with Z=1 after INX, then X=FF with N=1 after DEX.
- Program A9 5A, 8D 34 12 -> exactly one tick with address_o=1234, data_o=5A, data_valid_o=1, then FETCH at PC=8005.
- 4C 00 90 at 8000 -> next fetch address 9000; data_valid_i held low 3 ticks mid-operand -> request held stable, no state advance.
- Opcode 02 -> halted_o=1 and address_valid_o=0 persist; reset_i asserted mid-instruction -> outputs at reset values in the same clock; vector fetch restarts.

Source files
------------

// File: rtl/cpu_core.sv
// 6502-style core: vector fetch, load/transfer/inc/dec, JMP/STA abs, halt on illegal opcode.
// Optional debug outputs enabled by CPU_CORE_DEBUG_PORTS_EN.
module cpu_core #(
  parameter int          CLOCK_DIVIDER = 12,
  parameter logic [15:0] RESET_VECTOR  = 16'hFFFC,
  parameter logic [7:0]  STACK_RESET   = 8'hFD
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [7:0]  data_i,
  input  logic        data_valid_i,
  output logic [7:0]  data_o,
  output logic        data_valid_o,
  output logic [15:0] address_o,
  output logic        address_valid_o,
  output logic        halted_o
`ifdef CPU_CORE_DEBUG_PORTS_EN
  ,
  output logic        clock_ready_o,
  output logic [15:0] program_counter_o,
  output logic [7:0]  accumulator_o,
  output logic [7:0]  index_x_o,
  output logic [7:0]  index_y_o,
  output logic [7:0]  status_o,
  output logic [7:0]  stack_pointer_o,
  output logic [7:0]  opcode_o
`endif
);

  localparam int CW = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CLOCK_DIVIDER - 1);

  typedef enum logic [2:0] {
    S_RESET_LO,
    S_RESET_HI,
    S_FETCH,
    S_EXEC,
    S_OPERAND_LO,
    S_OPERAND_HI,
    S_WRITE,
    S_HALT
  } state_t;

  state_t state, n_state;
  logic [CW-1:0] count;
  logic tick, rd_ok;
  logic [15:0] pc, n_pc, n_addr;
  logic [7:0] a, x, y, p, opcode, lo;
  logic [7:0] n_a, n_x, n_y, n_p, n_opcode, n_lo, n_dout;
  logic n_avalid, n_dvalid, n_halted;

  function automatic logic is_imm(input logic [7:0] op);
    return op == 8'hA9 || op == 8'hA2 || op == 8'hA0;
  endfunction

  function automatic logic is_abs(input logic [7:0] op);
    return op == 8'h4C || op == 8'h8D;
  endfunction

  function automatic logic is_impl(input logic [7:0] op);
    return op == 8'hEA || op == 8'hAA || op == 8'hA8 ||
           op == 8'h8A || op == 8'h98 || op == 8'hE8 ||
           op == 8'hC8 || op == 8'hCA || op == 8'h88;
  endfunction

  function automatic logic [7:0] nz(input logic [7:0] r,
                                    input logic [7:0] f);
    return {r[7], f[6:2], r == 8'h00, f[0]};
  endfunction

  assign tick  = (count == CMAX);
  assign rd_ok = tick && data_valid_i;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) count <= '0;
    else if (tick) count <= '0;
    else count <= count + 1'b1;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state           <= S_RESET_LO;
      pc              <= 16'h0000;
      a               <= 8'h00;
      x               <= 8'h00;
      y               <= 8'h00;
      p               <= 8'h34;
      opcode          <= 8'h00;
      lo              <= 8'h00;
      address_o       <= RESET_VECTOR;
      address_valid_o <= 1'b1;
      data_o          <= 8'h00;
      data_valid_o    <= 1'b0;
      halted_o        <= 1'b0;
    end else begin
      state           <= n_state;
      pc              <= n_pc;
      a               <= n_a;
      x               <= n_x;
      y               <= n_y;
      p               <= n_p;
      opcode          <= n_opcode;
      lo              <= n_lo;
      address_o       <= n_addr;
      address_valid_o <= n_avalid;
      data_o          <= n_dout;
      data_valid_o    <= n_dvalid;
      halted_o        <= n_halted;
    end
  end

  always_comb begin
    n_state  = state;
    n_pc     = pc;
    n_a      = a;
    n_x      = x;
    n_y      = y;
    n_p      = p;
    n_opcode = opcode;
    n_lo     = lo;
    n_addr   = address_o;
    n_avalid = address_valid_o;
    n_dout   = data_o;
    n_dvalid = data_valid_o;
    n_halted = halted_o;
    if (tick) begin
      unique case (state)
        S_RESET_LO: if (rd_ok) begin
          n_pc[7:0] = data_i;
          n_addr    = RESET_VECTOR + 16'd1;
          n_state   = S_RESET_HI;
        end
        S_RESET_HI: if (rd_ok) begin
          n_pc[15:8] = data_i;
          n_addr     = {data_i, pc[7:0]};
          n_state    = S_FETCH;
        end
        S_FETCH: if (rd_ok) begin
          n_opcode = data_i;
          n_pc     = pc + 16'd1;
          unique case (1'b1)
            is_imm(data_i) || is_abs(data_i): begin
              n_addr  = pc + 16'd1;
              n_state = S_OPERAND_LO;
            end
            is_impl(data_i): begin
              n_avalid = 1'b0;
              n_state  = S_EXEC;
            end
            default: begin
              n_avalid = 1'b0;
              n_halted = 1'b1;
              n_state  = S_HALT;
            end
          endcase
        end
        S_EXEC: begin
          unique case (opcode)
            8'hAA: begin n_x = a; n_p = nz(n_x, p); end
            8'hA8: begin n_y = a; n_p = nz(n_y, p); end
            8'h8A: begin n_a = x; n_p = nz(n_a, p); end
            8'h98: begin n_a = y; n_p = nz(n_a, p); end
            8'hE8: begin n_x = x + 8'd1; n_p = nz(n_x, p); end
            8'hC8: begin n_y = y + 8'd1; n_p = nz(n_y, p); end
            8'hCA: begin n_x = x - 8'd1; n_p = nz(n_x, p); end
            8'h88: begin n_y = y - 8'd1; n_p = nz(n_y, p); end
            default: ;
          endcase
          n_addr   = pc;
          n_avalid = 1'b1;
          n_state  = S_FETCH;
        end
        S_OPERAND_LO: if (rd_ok) begin
          n_pc   = pc + 16'd1;
          n_addr = pc + 16'd1;
          if (is_imm(opcode)) begin
            unique case (opcode)
              8'hA9:   n_a = data_i;
              8'hA2:   n_x = data_i;
              default: n_y = data_i;
            endcase
            n_p     = nz(data_i, p);
            n_state = S_FETCH;
          end else begin
            n_lo    = data_i;
            n_state = S_OPERAND_HI;
          end
        end
        S_OPERAND_HI: if (rd_ok) begin
          if (opcode == 8'h4C) begin
            n_pc    = {data_i, lo};
            n_addr  = {data_i, lo};
            n_state = S_FETCH;
          end else begin
            n_pc     = pc + 16'd1;
            n_addr   = {data_i, lo};
            n_dout   = a;
            n_dvalid = 1'b1;
            n_state  = S_WRITE;
          end
        end
        S_WRITE: begin
          n_dvalid = 1'b0;
          n_addr   = pc;
          n_state  = S_FETCH;
        end
        default: ;
      endcase
    end
  end

`ifdef CPU_CORE_DEBUG_PORTS_EN
  // The subset has no stack ops, so SP never leaves its reset value.
  assign clock_ready_o     = tick;
  assign program_counter_o = pc;
  assign accumulator_o     = a;
  assign index_x_o         = x;
  assign index_y_o         = y;
  assign status_o          = p;
  assign stack_pointer_o   = STACK_RESET;
  assign opcode_o          = opcode;
`endif

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: vector fetch, loads, transfers,
// inc/dec wrap, STA write, JMP with stalls, halt and async reset.
module tb_cpu_core;
  localparam int CD = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_i;
  logic        data_valid_i = 1'b1;
  logic [7:0]  data_o;
  logic        data_valid_o;
  logic [15:0] address_o;
  logic        address_valid_o;
  logic        halted_o;
  logic [7:0]  mem [0:65535];
  int          pass_cnt = 0;
  int          chk_cnt = 0;

  always #5 clock = ~clock;

  cpu_core #(.CLOCK_DIVIDER(CD)) dut (
    .clock_i        (clock),
    .reset_i        (reset),
    .data_i         (data_i),
    .data_valid_i   (data_valid_i),
    .data_o         (data_o),
    .data_valid_o   (data_valid_o),
    .address_o      (address_o),
    .address_valid_o(address_valid_o),
    .halted_o       (halted_o)
  );

  assign data_i = mem[address_o];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n * CD) @(posedge clock);
    #1;
  endtask

  task automatic hard_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic boot();
    hard_reset();
    tick(2);
  endtask

  task automatic load(input logic [7:0] b0, b1, b2, b3, b4);
    mem[16'h8000] = b0;
    mem[16'h8001] = b1;
    mem[16'h8002] = b2;
    mem[16'h8003] = b3;
    mem[16'h8004] = b4;
  endtask

  initial begin
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;

    // reset state and vector fetch
    load(8'hA9, 8'h80, 8'hAA, 8'hE8, 8'hEA);
    @(posedge clock);
    #1;
    check("rst_addr", address_o, 16'hFFFC);
    check("rst_avalid", address_valid_o, 1);
    check("rst_dvalid", data_valid_o, 0);
    check("rst_dout", data_o, 0);
    check("rst_halt", halted_o, 0);
    check("rst_p", dut.p, 8'h34);
    reset = 1'b0;
    tick(1);
    check("vec_hi_addr", address_o, 16'hFFFD);
    tick(1);
    check("fetch0_addr", address_o, 16'h8000);
    check("pc_boot", dut.pc, 16'h8000);

    // LDA #80, TAX, INX
    tick(1);
    check("lda_op_addr", address_o, 16'h8001);
    tick(1);
    check("lda_a", dut.a, 8'h80);
    check("lda_p", dut.p, 8'hB4);
    check("fetch1_addr", address_o, 16'h8002);
    tick(1);
    check("tax_noreq", address_valid_o, 0);
    tick(1);
    check("tax_x", dut.x, 8'h80);
    check("fetch2_addr", address_o, 16'h8003);
    tick(2);
    check("inx_x", dut.x, 8'h81);
    check("inx_p", dut.p, 8'hB4);
    check("fetch3_addr", address_o, 16'h8004);

    // LDX #FF, INX wrap, DEX wrap
    load(8'hA2, 8'hFF, 8'hE8, 8'hCA, 8'hEA);
    boot();
    tick(2);
    check("ldx_x", dut.x, 8'hFF);
    tick(2);
    check("inxw_x", dut.x, 8'h00);
    check("inxw_p", dut.p, 8'h36);
    tick(2);
    check("dexw_x", dut.x, 8'hFF);
    check("dexw_p", dut.p, 8'hB4);

    // LDA #5A, STA $1234
    load(8'hA9, 8'h5A, 8'h8D, 8'h34, 8'h12);
    boot();
    tick(2);
    check("lda5a_p", dut.p, 8'h34);
    tick(3);
    check("sta_addr", address_o, 16'h1234);
    check("sta_dout", data_o, 8'h5A);
    check("sta_dvalid", data_valid_o, 1);
    check("sta_avalid", address_valid_o, 1);
    tick(1);
    check("sta_done", data_valid_o, 0);
    check("sta_next", address_o, 16'h8005);
    check("sta_p", dut.p, 8'h34);

    // JMP $9000 with a 3-tick stall on the low operand
    load(8'h4C, 8'h00, 8'h90, 8'hEA, 8'hEA);
    boot();
    tick(1);
    data_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("stall_addr", address_o, 16'h8001);
      check("stall_avalid", address_valid_o, 1);
      check("stall_pc", dut.pc, 16'h8001);
    end
    data_valid_i = 1'b1;
    tick(1);
    check("jmp_hi_addr", address_o, 16'h8002);
    tick(1);
    check("jmp_addr", address_o, 16'h9000);
    check("jmp_pc", dut.pc, 16'h9000);

    // illegal opcode halts
    load(8'h02, 8'hEA, 8'hEA, 8'hEA, 8'hEA);
    boot();
    tick(1);
    check("halt_flag", halted_o, 1);
    check("halt_avalid", address_valid_o, 0);
    tick(3);
    check("halt_hold", halted_o, 1);
    check("halt_hold_av", address_valid_o, 0);
    check("halt_dv", data_valid_o, 0);

    // async reset mid-instruction, then vector restart
    load(8'hA9, 8'h11, 8'hEA, 8'hEA, 8'hEA);
    boot();
    tick(1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_addr", address_o, 16'hFFFC);
    check("arst_avalid", address_valid_o, 1);
    check("arst_halt", halted_o, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick(1);
    check("rvec_hi", address_o, 16'hFFFD);
    tick(1);
    check("rvec_fetch", address_o, 16'h8000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
